// File: rtl/pipe_pkg.sv
// pipe_pkg
// Shared definitions for the pipeline stage registers of the five-stage CPU:
//   - occupancy state of a two-slot stage, encoded from the slot valid bits
//   - default field widths and reset payload constants
//   - the default-width slot payload layout (stages with other widths declare
//     the same layout locally from their own parameters)
package pipe_pkg;

    localparam int DEF_INSTR_W = 32;
    localparam int DEF_PC_W    = 32;
    localparam int DEF_EXT_W   = 8;

    localparam logic [DEF_PC_W-1:0]    DEF_RESET_PC  = 32'h0000_3000;
    localparam logic [DEF_INSTR_W-1:0] DEF_NOP_INSTR = '0;

    // Values are {main.valid, skid.valid}, so the state is read straight off
    // the slot flops; 2'b01 (skid without main) is unreachable.
    typedef enum logic [1:0] {
        S_EMPTY = 2'b00,
        S_ONE   = 2'b10,
        S_TWO   = 2'b11
    } state_t;

    typedef struct packed {
        logic [DEF_INSTR_W-1:0] instr;
        logic [DEF_PC_W-1:0]    pc;
        logic [DEF_EXT_W-1:0]   ext;
    } payload_t;

endpackage

// File: rtl/pipe_slot.sv
// pipe_slot
// One storage slot of a pipeline stage: a valid bit plus a payload word.
// Ports:
//   clk, reset      - clock and synchronous active-high reset
//   clear           - synchronous return to empty with the default payload
//   load            - capture load_valid / load_data
//   load_valid      - valid bit to capture
//   load_data [W]   - payload to capture
//   valid, data [W] - registered slot contents
// reset and clear have the same effect and take priority over load.
module pipe_slot #(
    parameter int            W            = 1,
    parameter logic [W-1:0]  DEFAULT_DATA = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         load,
    input  logic         load_valid,
    input  logic [W-1:0] load_data,
    output logic         valid,
    output logic [W-1:0] data
);

    // NOTE: the payload is reset along with the valid bit on purpose: an empty
    // slot must present the NOP/RESET_PC word downstream, never X.
    // NOTE: non-blocking assignments here so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            valid <= 1'b0;
            data  <= DEFAULT_DATA;
        end else if (load) begin
            valid <= load_valid;
            data  <= load_data;
        end
    end

endmodule

// File: rtl/pipe_reg_skid.sv
// pipe_reg_skid
// Valid/ready pipeline stage register carrying instruction, PC and a sideband
// field. A main slot drives the outputs; a skid slot catches the one beat that
// arrives in the cycle the downstream stalls, so in_ready can come from a flop
// and still sustain one beat per cycle.
// Ports:
//   clk, reset                      - clock, synchronous active-high reset
//   flush                           - synchronous squash of all held beats
//   in_valid, in_ready              - upstream handshake (in_ready registered)
//   in_instr, in_pc, in_ext         - upstream payload
//   out_valid, out_ready            - downstream handshake
//   out_instr, out_pc, out_ext      - head beat payload
//   occupancy [2]                   - beats held (0..2)
module pipe_reg_skid
    import pipe_pkg::*;
#(
    parameter int                 INSTR_W   = DEF_INSTR_W,
    parameter int                 PC_W      = DEF_PC_W,
    parameter int                 EXT_W     = DEF_EXT_W,
    parameter logic [PC_W-1:0]    RESET_PC  = PC_W'(DEF_RESET_PC),
    parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(DEF_NOP_INSTR)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic [PC_W-1:0]    in_pc,
    input  logic [EXT_W-1:0]   in_ext,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [PC_W-1:0]    out_pc,
    output logic [EXT_W-1:0]   out_ext,
    output logic [1:0]         occupancy
);

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [PC_W-1:0]    pc;
        logic [EXT_W-1:0]   ext;
    } slot_t;

    localparam int    SLOT_W       = $bits(slot_t);
    localparam slot_t DEFAULT_BEAT = '{instr: NOP_INSTR, pc: RESET_PC, ext: '0};

    slot_t  in_beat;
    slot_t  main_q;
    slot_t  skid_q;
    slot_t  main_src;
    logic   main_valid;
    logic   skid_valid;
    logic   main_load;
    logic   main_clear;
    logic   skid_load;
    logic   skid_clear;
    logic   skid_valid_next;
    logic   in_ready_q;
    logic   acc;
    logic   rel;
    state_t state;

    assign in_beat = '{instr: in_instr, pc: in_pc, ext: in_ext};
    assign state   = state_t'({main_valid, skid_valid});
    assign acc     = in_valid && in_ready_q;
    assign rel     = main_valid && out_ready;

    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        main_load  = 1'b0;
        main_clear = 1'b0;
        skid_load  = 1'b0;
        skid_clear = 1'b0;
        main_src   = in_beat;
        case (state)
            S_EMPTY: begin
                if (acc) main_load = 1'b1;
            end
            S_ONE: begin
                if (acc && rel)  main_load  = 1'b1;
                else if (acc)    skid_load  = 1'b1;
                else if (rel)    main_clear = 1'b1;
            end
            S_TWO: begin
                // in_ready is low here, so only a release can happen.
                if (rel) begin
                    main_load  = 1'b1;
                    main_src   = skid_q;
                    skid_clear = 1'b1;
                end
            end
            default: ;
        endcase
    end

    pipe_slot #(
        .W            (SLOT_W),
        .DEFAULT_DATA (DEFAULT_BEAT)
    ) u_main (
        .clk        (clk),
        .reset      (reset),
        .clear      (flush || main_clear),
        .load       (main_load),
        .load_valid (1'b1),
        .load_data  (main_src),
        .valid      (main_valid),
        .data       (main_q)
    );

    pipe_slot #(
        .W            (SLOT_W),
        .DEFAULT_DATA (DEFAULT_BEAT)
    ) u_skid (
        .clk        (clk),
        .reset      (reset),
        .clear      (flush || skid_clear),
        .load       (skid_load),
        .load_valid (1'b1),
        .load_data  (in_beat),
        .valid      (skid_valid),
        .data       (skid_q)
    );

    // in_ready gets its own flop tracking !skid.valid one edge ahead, so it is
    // a pure register output with no path from out_ready.
    always_comb begin
        skid_valid_next = skid_valid;
        if (flush)           skid_valid_next = 1'b0;
        else if (skid_load)  skid_valid_next = 1'b1;
        else if (skid_clear) skid_valid_next = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) in_ready_q <= 1'b1;
        else       in_ready_q <= !skid_valid_next;
    end

    assign in_ready  = in_ready_q;
    assign out_valid = main_valid;
    assign out_instr = main_q.instr;
    assign out_pc    = main_q.pc;
    assign out_ext   = main_q.ext;
    assign occupancy = {1'b0, main_valid} + {1'b0, skid_valid};

endmodule

// File: tb/tb_pipe_reg_skid.sv
// Bench for pipe_reg_skid: directed scenarios followed by randomized
// valid/ready/flush/reset traffic, all checked against a capacity-2 FIFO model.
module tb_pipe_reg_skid;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [7:0]  ext;
    } beat_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic [7:0]  in_ext;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [7:0]  out_ext;
    logic [1:0]  occupancy;

    int total = 0;
    int bad   = 0;

    beat_t model_q[$];

    always #5 clk = ~clk;

    pipe_reg_skid #(
        .INSTR_W   (32),
        .PC_W      (32),
        .EXT_W     (8),
        .RESET_PC  (32'h0000_3000),
        .NOP_INSTR (32'h0)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_instr  (in_instr),
        .in_pc     (in_pc),
        .in_ext    (in_ext),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .out_pc    (out_pc),
        .out_ext   (out_ext),
        .occupancy (occupancy)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Compare every output against the model: head of queue, or the
    // NOP/RESET_PC payload when nothing is held.
    task automatic check_all();
        int n;
        n = model_q.size();
        check("out_valid", 64'(out_valid), 64'(n > 0));
        check("in_ready",  64'(in_ready),  64'(n < 2));
        check("occupancy", 64'(occupancy), 64'(n));
        if (n > 0) begin
            check("out_instr", 64'(out_instr), 64'(model_q[0].instr));
            check("out_pc",    64'(out_pc),    64'(model_q[0].pc));
            check("out_ext",   64'(out_ext),   64'(model_q[0].ext));
        end else begin
            check("idle_instr", 64'(out_instr), 64'(32'h0));
            check("idle_pc",    64'(out_pc),    64'(32'h0000_3000));
            check("idle_ext",   64'(out_ext),   64'(8'h0));
        end
    endtask

    // Drive one cycle of inputs, advance the model across the edge, then
    // sample the DUT 1 time unit after the edge.
    task automatic cycle(input logic v, input logic [31:0] instr, input logic [31:0] pc,
                         input logic [7:0] ext, input logic rdy, input logic fl,
                         input logic rst);
        beat_t b;
        bit    accept;
        bit    release_;
        in_valid  = v;
        in_instr  = instr;
        in_pc     = pc;
        in_ext    = ext;
        out_ready = rdy;
        flush     = fl;
        reset     = rst;
        b.instr   = instr;
        b.pc      = pc;
        b.ext     = ext;
        accept    = v && (model_q.size() < 2);
        release_  = (model_q.size() > 0) && rdy;
        @(posedge clk);
        if (rst || fl) begin
            model_q.delete();
        end else begin
            if (release_) void'(model_q.pop_front());
            if (accept)   model_q.push_back(b);
        end
        #1;
        check_all();
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_instr = '0; in_pc = '0; in_ext = '0;

        // Reset held two cycles.
        cycle(0, 0, 0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 0, 0, 1);
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_in_ready",  64'(in_ready),  64'(1));
        check("rst_pc",        64'(out_pc),    64'(32'h3000));
        check("rst_occ",       64'(occupancy), 64'(0));

        // Back-to-back streaming: 1-cycle latency, in_ready stays high.
        cycle(1, 32'hA000_0001, 32'h3000, 8'h01, 1, 0, 0);
        check("stream_pc0", 64'(out_pc), 64'(32'h3000));
        cycle(1, 32'hA000_0002, 32'h3004, 8'h02, 1, 0, 0);
        check("stream_pc1", 64'(out_pc), 64'(32'h3004));
        cycle(1, 32'hA000_0003, 32'h3008, 8'h03, 1, 0, 0);
        check("stream_pc2", 64'(out_pc), 64'(32'h3008));
        check("stream_rdy", 64'(in_ready), 64'(1));
        cycle(0, 0, 0, 0, 1, 0, 0);

        // Downstream stall: second beat parks in skid, in_ready drops.
        cycle(1, 32'hB000_0000, 32'h3000, 8'h10, 0, 0, 0);
        cycle(1, 32'hB000_0004, 32'h3004, 8'h11, 0, 0, 0);
        check("stall_occ", 64'(occupancy), 64'(2));
        check("stall_rdy", 64'(in_ready),  64'(0));
        cycle(1, 32'hDEAD_BEEF, 32'h3FFC, 8'hEE, 0, 0, 0);   // ignored: not ready
        check("stall_head", 64'(out_pc), 64'(32'h3000));
        cycle(0, 0, 0, 0, 1, 0, 0);
        check("drain_pc1", 64'(out_pc), 64'(32'h3004));
        check("drain_rdy", 64'(in_ready), 64'(1));
        cycle(0, 0, 0, 0, 1, 0, 0);
        check("drain_empty", 64'(out_valid), 64'(0));

        // Flush at occupancy 2 with a concurrent beat offered.
        cycle(1, 32'hC000_0000, 32'h3000, 8'h20, 0, 0, 0);
        cycle(1, 32'hC000_0004, 32'h3004, 8'h21, 0, 0, 0);
        cycle(1, 32'hC000_000C, 32'h300C, 8'h22, 0, 1, 0);
        check("flush_valid", 64'(out_valid), 64'(0));
        check("flush_occ",   64'(occupancy), 64'(0));
        check("flush_pc",    64'(out_pc),    64'(32'h3000));
        check("flush_instr", 64'(out_instr), 64'(0));
        cycle(0, 0, 0, 0, 1, 0, 0);

        // Flush in ONE with an accepted beat: the beat is discarded.
        cycle(1, 32'hC100_0000, 32'h3040, 8'h30, 0, 0, 0);
        cycle(1, 32'hC100_0004, 32'h3044, 8'h31, 1, 1, 0);
        check("flush_acc_valid", 64'(out_valid), 64'(0));

        // Simultaneous accept and release in ONE.
        cycle(1, 32'hD000_0010, 32'h3010, 8'h40, 0, 0, 0);
        cycle(1, 32'hD000_0014, 32'h3014, 8'h41, 1, 0, 0);
        check("swap_pc",  64'(out_pc),    64'(32'h3014));
        check("swap_occ", 64'(occupancy), 64'(1));
        cycle(0, 0, 0, 0, 1, 0, 0);

        // Randomized traffic.
        for (int i = 0; i < 10000; i++) begin
            logic v, r, f, rs;
            v  = ($urandom_range(0, 3) != 0);
            r  = ($urandom_range(0, 2) != 0);
            f  = ($urandom_range(0, 63) == 0);
            rs = ($urandom_range(0, 499) == 0);
            cycle(v, $urandom, $urandom, 8'($urandom), r, f, rs);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
